// File: rtl/boltz_filter_pkg.sv
// boltz_filter_pkg: shared types, limits and saturation helper for the Boltzmann filter blocks
package boltz_filter_pkg;
  typedef enum logic {FILL, RUN} comb_state_t;
  localparam int MAX_COMB_DELAY = 1024;
  function automatic logic signed [31:0] sat_to_width(input logic signed [31:0] value, input int width);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    return value > hi ? hi : value < lo ? lo : value;
  endfunction
endpackage

// File: rtl/comb_filter_if.sv
// comb_filter_if: sample stream in, difference stream out; sat_o exists only with COMB_FILTER_SAT_EN
interface comb_filter_if #(parameter int WIDTH = 16);
  logic clr_i, valid_i, valid_o, primed_o;
  logic signed [WIDTH-1:0] data_i, data_o;
`ifdef COMB_FILTER_SAT_EN
  logic sat_o;
  modport master(output clr_i, valid_i, data_i, input valid_o, data_o, primed_o, sat_o);
  modport slave(input clr_i, valid_i, data_i, output valid_o, data_o, primed_o, sat_o);
`else
  modport master(output clr_i, valid_i, data_i, input valid_o, data_o, primed_o);
  modport slave(input clr_i, valid_i, data_i, output valid_o, data_o, primed_o);
`endif
endinterface

// File: rtl/comb_delay_line.sv
// comb_delay_line: DELAY-deep sample memory with wrapping pointer, read-before-write on the same slot
module comb_delay_line #(
  parameter int WIDTH  = 16,
  parameter int DELAY  = 8,
  parameter int ADDR_W = $clog2(DELAY)
) (
  input  logic             i_clk,
  input  logic             i_flush,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);
  logic [WIDTH-1:0]  r_ram [DELAY];
  logic [ADDR_W-1:0] r_ptr;
  assign o_data = r_ram[r_ptr];
  // pointer wraps explicitly so DELAY need not be a power of two
  always_ff @(posedge i_clk)
    if (i_flush) r_ptr <= '0;
    else if (i_we) r_ptr <= (r_ptr == ADDR_W'(DELAY - 1)) ? '0 : r_ptr + 1'b1;
  // storage kept free of reset so it maps onto LUT-RAM or block RAM
  always_ff @(posedge i_clk)
    if (i_we) r_ram[r_ptr] <= i_data;
endmodule

// File: rtl/comb_filter.sv
// comb_filter: streaming differentiator y[n] = x[n] - x[n-DELAY]; COMB_FILTER_SAT_EN selects saturation over wrap
module comb_filter
  import boltz_filter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DELAY = 8,
  localparam int ADDR_W = $clog2(DELAY)
) (
  input logic          clk_i,
  input logic          rst_i,
  comb_filter_if.slave bus
);
  if ((DELAY < 2) || (DELAY > MAX_COMB_DELAY)) begin : g_bad_delay
    $error("comb_filter: DELAY out of range");
  end
  comb_state_t             r_state;
  logic [ADDR_W-1:0]       r_fill;
  logic                    r_valid, r_primed;
  logic [WIDTH-1:0]        r_data;
  logic                    w_flush, w_acc;
  logic [WIDTH-1:0]        w_old_raw, w_old, w_res;
  logic signed [WIDTH:0]   w_diff;
  assign w_flush = !rst_i || bus.clr_i;
  assign w_acc   = bus.valid_i && !w_flush;
  comb_delay_line #(.WIDTH(WIDTH), .DELAY(DELAY), .ADDR_W(ADDR_W)) u_line (
    .i_clk(clk_i), .i_flush(w_flush), .i_we(w_acc), .i_data(bus.data_i), .o_data(w_old_raw)
  );
  assign w_old  = r_state == RUN ? w_old_raw : '0;
  assign w_diff = $signed({bus.data_i[WIDTH-1], bus.data_i}) - $signed({w_old[WIDTH-1], w_old});
`ifdef COMB_FILTER_SAT_EN
  logic               r_sat, w_clip;
  logic signed [31:0] w_sat;
  assign w_sat     = sat_to_width(32'(w_diff), WIDTH);
  assign w_res     = w_sat[WIDTH-1:0];
  assign w_clip    = w_sat != 32'(w_diff);
  assign bus.sat_o = r_sat;
  // clip flag travels with the output pulse
  always_ff @(posedge clk_i)
    if (w_flush) r_sat <= 1'b0;
    else r_sat <= bus.valid_i && w_clip;
`else
  assign w_res = WIDTH'(w_diff);
`endif
  assign bus.valid_o  = r_valid;
  assign bus.data_o   = r_data;
  assign bus.primed_o = r_primed;
  // fill/run sequencing and registered outputs; reset outranks flush, flush outranks a sample
  always_ff @(posedge clk_i)
    if (w_flush) begin
      r_state  <= FILL;
      r_fill   <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_primed <= 1'b0;
    end else begin
      r_valid <= bus.valid_i;
      if (bus.valid_i) begin
        r_data   <= w_res;
        r_primed <= r_state == RUN;
        r_fill   <= r_state == FILL ? r_fill + 1'b1 : r_fill;
        r_state  <= (r_state == FILL && r_fill == ADDR_W'(DELAY - 1)) ? RUN : r_state;
      end
    end
endmodule
